// File: rtl/bus_fabric_pkg.sv
// rtl/bus_fabric_pkg.sv - shared types and constants for the native-bus interconnect
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0]  ERR_NONE    = 2'b00;
    localparam logic [1:0]  ERR_DECODE  = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBADC_0DE0;

    // Slot index width covers the full 1..16 slot range.
    localparam int IDX_W = 4;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational table-driven priority address decoder
module bus_addr_decode
    import bus_fabric_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [NSLV-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest matching slot is the last writer and wins.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit       = 1'b1;
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - single-master native-bus fabric with timeout and sticky error status
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}},
    parameter int                 TIMEOUT  = 255,
    parameter logic [31:0]        ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_valid,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    output logic                 m_ready,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_valid,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [NSLV-1:0]      s_ready,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic                 err_irq,
    output logic [1:0]           err_code,
    output logic [31:0]          err_addr,
    input  logic                 err_clr
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q;
    logic [15:0]        cnt_q;
    logic               dec_hit;
    logic [NSLV-1:0]    dec_onehot;
    logic [IDX_W-1:0]   dec_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               timeout_hit;
    logic               accept_hit, accept_miss, done_ok, done_to;
    logic               err_set;
    logic [1:0]         err_set_code;
    logic [31:0]        err_set_addr;

    bus_addr_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr   (m_addr),
        .hit    (dec_hit),
        .onehot (dec_onehot),
        .idx    (dec_idx)
    );

    // Only the latched slot's ready/rdata are looked at; other slots are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        accept_hit   = 1'b0;
        accept_miss  = 1'b0;
        done_ok      = 1'b0;
        done_to      = 1'b0;
        err_set      = 1'b0;
        err_set_code = ERR_NONE;
        err_set_addr = s_addr;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (dec_hit) begin
                        accept_hit = 1'b1;
                        state_d    = ACTIVE;
                    end else begin
                        accept_miss  = 1'b1;
                        state_d      = RESP;
                        err_set      = 1'b1;
                        err_set_code = ERR_DECODE;
                        err_set_addr = m_addr;
                    end
                end
            end
            ACTIVE: begin
                // A ready arriving on the final counted cycle still wins over the timeout.
                if (sel_ready) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    done_to      = 1'b1;
                    state_d      = RESP;
                    err_set      = 1'b1;
                    err_set_code = ERR_TIMEOUT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            m_ready  <= 1'b0;
            m_rdata  <= '0;
            s_valid  <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            err_irq  <= 1'b0;
            err_code <= ERR_NONE;
            err_addr <= '0;
        end else begin
            state_q <= state_d;
            m_ready <= (state_d == RESP);
            if (accept_hit) begin
                s_valid <= dec_onehot;
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                sel_q   <= dec_idx;
                cnt_q   <= '0;
            end
            if (accept_miss || done_to) begin
                m_rdata <= ERR_DATA;
            end
            if (done_ok) begin
                m_rdata <= sel_rdata;
            end
            if (done_ok || done_to) begin
                s_valid <= '0;
                cnt_q   <= '0;
            end else if (state_q == ACTIVE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (err_clr) begin
                err_irq  <= 1'b0;
                err_code <= ERR_NONE;
                err_addr <= '0;
            end
            // The first error is kept; a clear in the same cycle makes room for the new one.
            if (err_set && (!err_irq || err_clr)) begin
                err_irq  <= 1'b1;
                err_code <= err_set_code;
                err_addr <= err_set_addr;
            end
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - directed self-checking bench for bus_fabric
module tb_bus_fabric;
    localparam int NSLV = 4;
    localparam logic [NSLV*32-1:0] BASE = {32'h0300_0000, 32'h0000_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [NSLV*32-1:0] MASK = {32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_F000};
    localparam logic [31:0] ED = 32'hBADC_0DE0;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic [31:0]       m_addr, m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic [NSLV-1:0]   s_valid;
    logic [31:0]       s_addr, s_wdata;
    logic [3:0]        s_wstrb;
    logic [NSLV-1:0]   s_ready;
    logic [NSLV*32-1:0] s_rdata;
    logic              err_irq;
    logic [1:0]        err_code;
    logic [31:0]       err_addr;
    logic              err_clr;

    int checks = 0;
    int errors = 0;
    int n;

    bus_fabric #(
        .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8), .ERR_DATA(ED)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_irq(err_irq), .err_code(err_code), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        step();
        m_valid = 1'b0;
    endtask

    // Runs a request that never sees s_ready; returns how many cycles s_valid stayed high.
    task automatic run_timeout(input logic [31:0] addr, output int cycles);
        s_ready = '0;
        request(addr, 32'h0, 4'h0);
        cycles = 0;
        while (s_valid != '0 && cycles < 20) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        reset   = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'h1111_1111};
        err_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_err_irq", 32'(err_irq), 32'h0);
        check("rst_err_code", 32'(err_code), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Decode hit on slot 1, ready in the first ACTIVE cycle
        s_ready = 4'b0010;
        request(32'h0200_0008, 32'h0, 4'h0);
        check("hit_s_valid", 32'(s_valid), 32'h2);
        check("hit_s_addr", s_addr, 32'h0200_0008);
        check("hit_m_ready_early", 32'(m_ready), 32'h0);
        step();
        check("hit_m_ready", 32'(m_ready), 32'h1);
        check("hit_m_rdata", m_rdata, 32'h1234_5678);
        check("hit_s_valid_drop", 32'(s_valid), 32'h0);
        step();
        check("hit_m_ready_pulse", 32'(m_ready), 32'h0);
        check("hit_m_rdata_hold", m_rdata, 32'h1234_5678);
        s_ready = '0;

        // Overlap priority: slots 0 and 2 both match; write path
        request(32'h0000_0100, 32'hCAFE_F00D, 4'hF);
        check("ovl_s_valid", 32'(s_valid), 32'h1);
        check("ovl_s_wdata", s_wdata, 32'hCAFE_F00D);
        check("ovl_s_wstrb", 32'(s_wstrb), 32'hF);
        s_ready = 4'b0101;
        step();
        check("ovl_m_ready", 32'(m_ready), 32'h1);
        check("ovl_m_rdata", m_rdata, 32'h1111_1111);
        s_ready = '0;
        step();

        // Timeout on clean error state, then a late ready
        run_timeout(32'h0200_0000, n);
        check("to_cycles", 32'(n), 32'd8);
        check("to_m_ready", 32'(m_ready), 32'h1);
        check("to_m_rdata", m_rdata, ED);
        check("to_err_code", 32'(err_code), 32'h2);
        check("to_err_addr", err_addr, 32'h0200_0000);
        s_ready = 4'b0010;
        step();
        check("late_m_ready", 32'(m_ready), 32'h0);
        check("late_s_valid", 32'(s_valid), 32'h0);
        step();
        check("late_m_ready2", 32'(m_ready), 32'h0);
        s_ready = '0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err_irq", 32'(err_irq), 32'h0);
        check("clr_err_code", 32'(err_code), 32'h0);
        check("clr_err_addr", err_addr, 32'h0);

        // Ready on the final counted cycle counts as success
        request(32'h0200_0004, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) step();
        check("edge_s_valid", 32'(s_valid), 32'h2);
        s_ready = 4'b0010;
        step();
        s_ready = '0;
        check("edge_m_ready", 32'(m_ready), 32'h1);
        check("edge_m_rdata", m_rdata, 32'h1234_5678);
        check("edge_err_irq", 32'(err_irq), 32'h0);
        step();

        // Decode miss
        request(32'hF000_0000, 32'h0, 4'h0);
        check("miss_m_ready", 32'(m_ready), 32'h1);
        check("miss_m_rdata", m_rdata, ED);
        check("miss_s_valid", 32'(s_valid), 32'h0);
        check("miss_err_irq", 32'(err_irq), 32'h1);
        check("miss_err_code", 32'(err_code), 32'h1);
        check("miss_err_addr", err_addr, 32'hF000_0000);
        step();
        check("miss_m_ready_pulse", 32'(m_ready), 32'h0);

        // Sticky: a later timeout does not overwrite the first error
        run_timeout(32'h0200_0000, n);
        check("sticky_cycles", 32'(n), 32'd8);
        check("sticky_err_code", 32'(err_code), 32'h1);
        check("sticky_err_addr", err_addr, 32'hF000_0000);
        step();

        // Clear coinciding with a new miss records the new miss
        err_clr = 1'b1;
        request(32'hE000_0000, 32'h0, 4'h0);
        err_clr = 1'b0;
        check("clrmiss_err_irq", 32'(err_irq), 32'h1);
        check("clrmiss_err_code", 32'(err_code), 32'h1);
        check("clrmiss_err_addr", err_addr, 32'hE000_0000);
        step();

        // Reset during a slave wait
        request(32'h0300_0000, 32'h0, 4'h0);
        check("rma_s_valid", 32'(s_valid), 32'h8);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rma_s_valid_rst", 32'(s_valid), 32'h0);
        check("rma_m_ready_rst", 32'(m_ready), 32'h0);
        step();
        check("rma_m_ready_after", 32'(m_ready), 32'h0);
        s_ready = 4'b1000;
        request(32'h0300_0004, 32'h0, 4'h0);
        check("rma_next_s_valid", 32'(s_valid), 32'h8);
        step();
        check("rma_next_m_ready", 32'(m_ready), 32'h1);
        check("rma_next_m_rdata", m_rdata, 32'h4444_4444);
        s_ready = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
